// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the UART command controller: opcodes,
// FSM state encoding, default reply bytes and the command payload layout.
package uart_cmd_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned CMD_W   = 24;
  localparam int unsigned TEL_W   = 16;
  localparam int unsigned FRAME_W = 24;
  localparam int unsigned LEN_W   = 2;
  localparam int unsigned STATE_W = 3;

  localparam logic [BYTE_W-1:0] OP_WR   = 8'h01;
  localparam logic [BYTE_W-1:0] OP_RD   = 8'h02;
  localparam logic [BYTE_W-1:0] OP_PING = 8'h03;

  localparam logic [BYTE_W-1:0] ACK_DEF     = 8'hA5;
  localparam logic [BYTE_W-1:0] NAK_DEF     = 8'hEE;
  localparam logic [BYTE_W-1:0] TEL_HDR_DEF = 8'h7E;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_CMD  = 3'd1;
  localparam state_t ST_EXEC = 3'd2;
  localparam state_t ST_TEL  = 3'd3;
  localparam state_t ST_SEND = 3'd4;
  localparam state_t ST_WAIT = 3'd5;

  typedef struct packed {
    logic [BYTE_W-1:0] op;
    logic [BYTE_W-1:0] addr;
    logic [BYTE_W-1:0] data;
  } cmd_t;

  // Only the low 16 register addresses exist; any high-nibble bit is a bad address.
  function automatic logic addr_ok(input logic [BYTE_W-1:0] addr);
    return addr[BYTE_W-1:ADDR_W] == '0;
  endfunction

endpackage

// File: rtl/uart_tx_seq.sv
// Transmit sequencer: holds up to three reply bytes and walks them out
// MSB first through the trmt / tx_done handshake (SEND/WAIT loop).
module uart_tx_seq
  import uart_cmd_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [FRAME_W-1:0] frame,
  input  logic [LEN_W-1:0]   len,
  input  logic               tx_done,
  output logic               trmt,
  output logic [BYTE_W-1:0]  tx_data,
  output logic               last_c
);

  state_t               state, state_nx;
  logic [FRAME_W-1:0]   shift_q, shift_nx;
  logic [LEN_W-1:0]     rem_q, rem_nx;
  logic                 trmt_nx;
  logic [BYTE_W-1:0]    tx_data_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      shift_q <= '0;
      rem_q   <= '0;
      trmt    <= 1'b0;
      tx_data <= '0;
    end else begin
      state   <= state_nx;
      shift_q <= shift_nx;
      rem_q   <= rem_nx;
      trmt    <= trmt_nx;
      tx_data <= tx_data_nx;
    end
  end

  // The byte on tx_data stays put until tx_done; trmt is raised on entry to SEND.
  always_comb begin
    state_nx   = state;
    shift_nx   = shift_q;
    rem_nx     = rem_q;
    trmt_nx    = 1'b0;
    tx_data_nx = tx_data;
    last_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load) begin
          shift_nx   = frame;
          rem_nx     = len;
          tx_data_nx = frame[FRAME_W-1 -: BYTE_W];
          trmt_nx    = 1'b1;
          state_nx   = ST_SEND;
        end
      end
      ST_SEND: state_nx = ST_WAIT;
      ST_WAIT: begin
        if (tx_done) begin
          if (rem_q > LEN_W'(1)) begin
            rem_nx     = rem_q - LEN_W'(1);
            shift_nx   = {shift_q[FRAME_W-BYTE_W-1:0], BYTE_W'(0)};
            tx_data_nx = shift_q[FRAME_W-BYTE_W-1 -: BYTE_W];
            trmt_nx    = 1'b1;
            state_nx   = ST_SEND;
          end else begin
            last_c   = 1'b1;
            rem_nx   = '0;
            shift_nx = '0;
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command controller behind UART_comm: arbitrates commands against telemetry,
// executes register read/write/ping and hands reply bytes to the tx sequencer.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] ACK_BYTE = ACK_DEF,
  parameter logic [7:0] NAK_BYTE = NAK_DEF,
  parameter logic [7:0] TEL_HDR  = TEL_HDR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_rdy,
  input  logic [CMD_W-1:0]  cmd,
  output logic              clr_cmd_rdy,
  output logic              trmt,
  output logic [BYTE_W-1:0] tx_data,
  input  logic              tx_done,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [BYTE_W-1:0] reg_wdata,
  input  logic [BYTE_W-1:0] reg_rdata,
  input  logic              tel_req,
  input  logic [TEL_W-1:0]  tel_data,
  output logic              tel_gnt
);

  state_t              state, state_nx;
  logic                prio_tel, prio_tel_nx;
  logic [BYTE_W-1:0]   op_q, op_nx;
  logic                addr_ok_q, addr_ok_nx;
  logic                clr_nx, gnt_nx, we_nx;
  logic [ADDR_W-1:0]   addr_nx;
  logic [BYTE_W-1:0]   wdata_nx;

  cmd_t                cmd_in_c;
  logic [BYTE_W-1:0]   reply_c;
  logic                seq_load_c;
  logic [FRAME_W-1:0]  seq_frame_c;
  logic [LEN_W-1:0]    seq_len_c;
  logic                seq_last_c;

  assign cmd_in_c = cmd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      prio_tel    <= 1'b0;
      op_q        <= '0;
      addr_ok_q   <= 1'b0;
      clr_cmd_rdy <= 1'b0;
      tel_gnt     <= 1'b0;
      reg_we      <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
    end else begin
      state       <= state_nx;
      prio_tel    <= prio_tel_nx;
      op_q        <= op_nx;
      addr_ok_q   <= addr_ok_nx;
      clr_cmd_rdy <= clr_nx;
      tel_gnt     <= gnt_nx;
      reg_we      <= we_nx;
      reg_addr    <= addr_nx;
      reg_wdata   <= wdata_nx;
    end
  end

  // Reply decode for the latched command; read data is sampled live during EXEC.
  always_comb begin
    reply_c = NAK_BYTE;
    case (op_q)
      OP_WR:   reply_c = addr_ok_q ? ACK_BYTE : NAK_BYTE;
      OP_RD:   reply_c = addr_ok_q ? reg_rdata : NAK_BYTE;
      OP_PING: reply_c = ACK_BYTE;
      default: reply_c = NAK_BYTE;
    endcase
  end

  always_comb begin
    state_nx    = state;
    prio_tel_nx = prio_tel;
    op_nx       = op_q;
    addr_ok_nx  = addr_ok_q;
    clr_nx      = 1'b0;
    gnt_nx      = 1'b0;
    we_nx       = 1'b0;
    addr_nx     = reg_addr;
    wdata_nx    = reg_wdata;
    seq_load_c  = 1'b0;
    seq_frame_c = '0;
    seq_len_c   = '0;
    case (state)
      // Priority only flips when both sources compete.
      ST_IDLE: begin
        if (cmd_rdy && (!tel_req || !prio_tel)) begin
          clr_nx   = 1'b1;
          state_nx = ST_CMD;
          if (tel_req) prio_tel_nx = 1'b1;
        end else if (tel_req) begin
          gnt_nx   = 1'b1;
          state_nx = ST_TEL;
          if (cmd_rdy) prio_tel_nx = 1'b0;
        end
      end
      ST_CMD: begin
        op_nx      = cmd_in_c.op;
        addr_ok_nx = addr_ok(cmd_in_c.addr);
        addr_nx    = cmd_in_c.addr[ADDR_W-1:0];
        wdata_nx   = cmd_in_c.data;
        we_nx      = (cmd_in_c.op == OP_WR) && addr_ok(cmd_in_c.addr);
        state_nx   = ST_EXEC;
      end
      ST_EXEC: begin
        seq_load_c  = 1'b1;
        seq_frame_c = {reply_c, (FRAME_W-BYTE_W)'(0)};
        seq_len_c   = LEN_W'(1);
        state_nx    = ST_SEND;
      end
      ST_TEL: begin
        seq_load_c  = 1'b1;
        seq_frame_c = {TEL_HDR, tel_data};
        seq_len_c   = LEN_W'(3);
        state_nx    = ST_SEND;
      end
      ST_SEND: state_nx = ST_WAIT;
      ST_WAIT: begin
        if (tx_done) state_nx = seq_last_c ? ST_IDLE : ST_SEND;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  uart_tx_seq u_tx_seq (
    .clk     (clk),
    .rst     (rst),
    .load    (seq_load_c),
    .frame   (seq_frame_c),
    .len     (seq_len_c),
    .tx_done (tx_done),
    .trmt    (trmt),
    .tx_data (tx_data),
    .last_c  (seq_last_c)
  );

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: register bank, UART responder and a transaction-level
// reference model of replies, arbitration order and register contents.
module tb_uart_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_rdy = 1'b0;
  logic [23:0] cmd = '0;
  logic        clr_cmd_rdy;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done = 1'b0;
  logic        reg_we;
  logic [3:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic        tel_req = 1'b0;
  logic [15:0] tel_data = '0;
  logic        tel_gnt;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] bank [16];
  logic [7:0] mregs [16];
  int         we_cnt = 0;
  int         mwe = 0;
  bit         mprio = 1'b0;   // model: 1 = telemetry holds priority
  logic [7:0] rx_q [$];
  bit         order_q [$];    // 0 = command served, 1 = telemetry served
  int         done_cnt = 0;
  int         cmd_rearm = 0;
  int         tel_rearm = 0;
  bit         stall = 1'b0;

  always #5 clk = ~clk;

  uart_cmd_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_rdy     (cmd_rdy),
    .cmd         (cmd),
    .clr_cmd_rdy (clr_cmd_rdy),
    .trmt        (trmt),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .reg_we      (reg_we),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_rdata   (reg_rdata),
    .tel_req     (tel_req),
    .tel_data    (tel_data),
    .tel_gnt     (tel_gnt)
  );

  assign reg_rdata = bank[reg_addr];

  // Register bank and grant-order monitor, sampling the values of the cycle just ended.
  always @(posedge clk) begin
    if (reg_we) begin
      bank[reg_addr] = reg_wdata;
      we_cnt = we_cnt + 1;
    end
    if (clr_cmd_rdy) order_q.push_back(1'b0);
    if (tel_gnt) order_q.push_back(1'b1);
  end

  // UART_comm side: cmd_rdy falls once cleared, optionally re-raised for back-to-back traffic.
  always @(posedge clk) begin
    if (clr_cmd_rdy && !rst) begin
      #1 cmd_rdy = 1'b0;
      if (cmd_rearm > 0) begin
        cmd_rearm = cmd_rearm - 1;
        @(posedge clk);
        #1 cmd_rdy = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (tel_gnt && !rst) begin
      #1 tel_req = 1'b0;
      if (tel_rearm > 0) begin
        tel_rearm = tel_rearm - 1;
        @(posedge clk);
        #1 tel_req = 1'b1;
      end
    end
  end

  // Transmitter: captures each byte, holds tx_done off for a random time, checks tx_data stays stable.
  initial begin : responder
    logic [7:0] b;
    int d;
    int k;
    bit ab;
    forever begin
      @(posedge clk); #1;
      while (trmt === 1'b1 && !rst) begin
        b = tx_data;
        rx_q.push_back(b);
        d = $urandom_range(1, 4);
        k = 0;
        ab = 1'b0;
        while ((k < d || stall) && !ab && k < 2000) begin
          @(posedge clk); #1;
          k++;
          if (rst) ab = 1'b1;
          else begin
            n_checks++;
            if (trmt !== 1'b0 || tx_data !== b) begin
              n_fail++;
              $display("FAIL tx_hold: trmt=%0b tx_data=%h, required trmt=0 tx_data=%h", trmt, tx_data, b);
            end
          end
        end
        if (!ab) begin
          tx_done = 1'b1;
          @(posedge clk); #1;
          tx_done = 1'b0;
          done_cnt++;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1);
  end

  // Reference reply for one command; applies a valid write to the model registers.
  function automatic logic [7:0] model_reply(input logic [23:0] c);
    logic [7:0] op;
    logic [7:0] a;
    op = c[23:16];
    a  = c[15:8];
    if (op == 8'h01) begin
      if (a < 8'd16) begin
        mregs[a[3:0]] = c[7:0];
        mwe++;
        return 8'hA5;
      end
      return 8'hEE;
    end
    if (op == 8'h02) return (a < 8'd16) ? mregs[a[3:0]] : 8'hEE;
    if (op == 8'h03) return 8'hA5;
    return 8'hEE;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    int k;
    k = 0;
    while (done_cnt < target && k < budget) begin
      tick();
      k++;
    end
    ok = (done_cnt >= target);
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    mprio = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_checks++;
    if ({clr_cmd_rdy, trmt, reg_we, tel_gnt, tx_data, reg_addr, reg_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: clr=%b trmt=%b we=%b gnt=%b tx_data=%h addr=%h wdata=%h, required all 0",
               clr_cmd_rdy, trmt, reg_we, tel_gnt, tx_data, reg_addr, reg_wdata);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write();
    logic [7:0] exp;
    int base;
    bit ok;
    rx_q.delete();
    base = done_cnt;
    exp = model_reply(24'h01053C);
    cmd = 24'h01053C;
    cmd_rdy = 1'b1;
    tick();
    n_checks++;
    if (clr_cmd_rdy !== 1'b1 || trmt !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_cycle1: clr=%b trmt=%b, required clr=1 trmt=0", clr_cmd_rdy, trmt);
    end
    tick();
    n_checks++;
    if (reg_we !== 1'b1 || reg_addr !== 4'h5 || reg_wdata !== 8'h3C || clr_cmd_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_cycle2: we=%b addr=%h wdata=%h clr=%b, required we=1 addr=5 wdata=3c clr=0",
               reg_we, reg_addr, reg_wdata, clr_cmd_rdy);
    end
    tick();
    n_checks++;
    if (trmt !== 1'b1 || tx_data !== exp || reg_we !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_cycle3: trmt=%b tx_data=%h we=%b, required trmt=1 tx_data=%h we=0", trmt, tx_data, reg_we, exp);
    end
    wait_done(base + 1, 100, ok);
    n_checks++;
    if (!ok || rx_q.size() != 1 || bank[5] !== 8'h3C) begin
      n_fail++;
      $display("FAIL wr_done: ok=%0b bytes=%0d bank5=%h, required ok=1 bytes=1 bank5=3c", ok, rx_q.size(), bank[5]);
    end
  endtask

  task automatic test_read();
    logic [7:0] exp;
    int base;
    int we0;
    bit ok;
    rx_q.delete();
    base = done_cnt;
    we0 = we_cnt;
    exp = model_reply(24'h020500);
    cmd = 24'h020500;
    cmd_rdy = 1'b1;
    wait_done(base + 1, 100, ok);
    n_checks++;
    if (!ok || rx_q.size() != 1 || rx_q[0] !== exp) begin
      n_fail++;
      $display("FAIL rd_reply: ok=%0b bytes=%0d first=%h, required 1 byte %h", ok, rx_q.size(),
               (rx_q.size() > 0) ? rx_q[0] : 8'h00, exp);
    end
    n_checks++;
    if (we_cnt != we0) begin
      n_fail++;
      $display("FAIL rd_no_we: we pulses=%0d, required 0", we_cnt - we0);
    end
  endtask

  task automatic test_nak();
    logic [23:0] cmds [3];
    logic [7:0] exp;
    int base;
    int we0;
    bit ok;
    cmds[0] = 24'h7F0000;
    cmds[1] = 24'h011200;
    cmds[2] = 24'h030000;
    we0 = we_cnt;
    for (int i = 0; i < 3; i++) begin
      rx_q.delete();
      base = done_cnt;
      exp = model_reply(cmds[i]);
      cmd = cmds[i];
      cmd_rdy = 1'b1;
      wait_done(base + 1, 100, ok);
      n_checks++;
      if (!ok || rx_q.size() != 1 || rx_q[0] !== exp) begin
        n_fail++;
        $display("FAIL nak_reply cmd=%h: ok=%0b bytes=%0d first=%h, required 1 byte %h", cmds[i], ok, rx_q.size(),
                 (rx_q.size() > 0) ? rx_q[0] : 8'h00, exp);
      end
    end
    n_checks++;
    if (we_cnt != we0) begin
      n_fail++;
      $display("FAIL nak_no_we: we pulses=%0d, required 0", we_cnt - we0);
    end
  endtask

  task automatic test_telemetry();
    logic [7:0] exp [3];
    int base;
    bit ok;
    exp[0] = 8'h7E;
    exp[1] = 8'hBE;
    exp[2] = 8'hEF;
    rx_q.delete();
    base = done_cnt;
    tel_data = 16'hBEEF;
    tel_req = 1'b1;
    tick();
    n_checks++;
    if (tel_gnt !== 1'b1 || trmt !== 1'b0) begin
      n_fail++;
      $display("FAIL tel_cycle1: gnt=%b trmt=%b, required gnt=1 trmt=0", tel_gnt, trmt);
    end
    tick();
    n_checks++;
    if (trmt !== 1'b1 || tx_data !== 8'h7E || tel_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL tel_cycle2: trmt=%b tx_data=%h gnt=%b, required trmt=1 tx_data=7e gnt=0", trmt, tx_data, tel_gnt);
    end
    tel_data = 16'h0000;
    wait_done(base + 3, 200, ok);
    n_checks++;
    if (!ok || rx_q.size() != 3) begin
      n_fail++;
      $display("FAIL tel_count: ok=%0b bytes=%0d, required 3", ok, rx_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= rx_q.size() || rx_q[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL tel_byte%0d: got %h, required %h", i, (i < rx_q.size()) ? rx_q[i] : 8'h00, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit exp_ord [$];
    logic [7:0] exp_b [$];
    logic [7:0] rep;
    int rc;
    int rt;
    int base;
    bit ok;
    bit pick;
    do_reset();
    rx_q.delete();
    order_q.delete();
    base = done_cnt;
    rc = 2;
    rt = 2;
    while (rc > 0 || rt > 0) begin
      if (rc > 0 && rt > 0) begin
        pick = mprio;
        mprio = ~mprio;
      end else pick = (rt > 0);
      exp_ord.push_back(pick);
      if (pick) begin
        rt--;
        exp_b.push_back(8'h7E); exp_b.push_back(8'h12); exp_b.push_back(8'h34);
      end else begin
        rc--;
        rep = model_reply(24'h030000);
        exp_b.push_back(rep);
      end
    end
    cmd = 24'h030000;
    tel_data = 16'h1234;
    cmd_rearm = 1;
    tel_rearm = 1;
    cmd_rdy = 1'b1;
    tel_req = 1'b1;
    wait_done(base + exp_b.size(), 500, ok);
    n_checks++;
    if (!ok || order_q.size() != exp_ord.size()) begin
      n_fail++;
      $display("FAIL b2b_count: ok=%0b grants=%0d, required %0d", ok, order_q.size(), exp_ord.size());
    end
    for (int i = 0; i < exp_ord.size(); i++) begin
      n_checks++;
      if (i >= order_q.size() || order_q[i] !== exp_ord[i]) begin
        n_fail++;
        $display("FAIL b2b_order%0d: got %0d, required %0d (0=cmd 1=tel)", i,
                 (i < order_q.size()) ? order_q[i] : 1'b0, exp_ord[i]);
      end
    end
    for (int i = 0; i < exp_b.size(); i++) begin
      n_checks++;
      if (i >= rx_q.size() || rx_q[i] !== exp_b[i]) begin
        n_fail++;
        $display("FAIL b2b_byte%0d: got %h, required %h", i, (i < rx_q.size()) ? rx_q[i] : 8'h00, exp_b[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_b [4];
    logic [15:0] d2;
    int base;
    int k;
    bit ok;
    rx_q.delete();
    stall = 1'b1;
    tel_data = 16'($urandom);
    tel_req = 1'b1;
    k = 0;
    while (rx_q.size() < 1 && k < 50) begin
      tick();
      k++;
    end
    n_checks++;
    if (rx_q.size() < 1) begin
      n_fail++;
      $display("FAIL rstmid_start: bytes=%0d, required 1 before reset", rx_q.size());
    end
    tick();
    tick();
    d2 = 16'($urandom);
    cmd = 24'h020500;
    cmd_rdy = 1'b1;
    tel_data = d2;
    tel_req = 1'b1;
    rst = 1'b1;
    tick();
    n_checks++;
    if ({clr_cmd_rdy, trmt, reg_we, tel_gnt, tx_data, reg_addr, reg_wdata} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: clr=%b trmt=%b we=%b gnt=%b tx_data=%h addr=%h wdata=%h, required all 0",
               clr_cmd_rdy, trmt, reg_we, tel_gnt, tx_data, reg_addr, reg_wdata);
    end
    tick();
    n_checks++;
    if (trmt !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_trmt: trmt=%b, required 0", trmt);
    end
    rst = 1'b0;
    mprio = 1'b1;    // both pending after reset: command wins, priority passes to telemetry
    stall = 1'b0;
    rx_q.delete();
    order_q.delete();
    base = done_cnt;
    exp_b[0] = model_reply(24'h020500);
    exp_b[1] = 8'h7E;
    exp_b[2] = d2[15:8];
    exp_b[3] = d2[7:0];
    wait_done(base + 4, 300, ok);
    n_checks++;
    if (!ok || order_q.size() != 2 || order_q[0] !== 1'b0 || order_q[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_order: ok=%0b grants=%0d first=%0d, required 2 grants cmd then tel", ok, order_q.size(),
               (order_q.size() > 0) ? order_q[0] : 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= rx_q.size() || rx_q[i] !== exp_b[i]) begin
        n_fail++;
        $display("FAIL rstmid_byte%0d: got %h, required %h", i, (i < rx_q.size()) ? rx_q[i] : 8'h00, exp_b[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_b [$];
    bit exp_ord [$];
    logic [23:0] c;
    logic [15:0] t;
    logic [7:0] op;
    logic [7:0] a;
    int r;
    int kind;
    int base;
    bit ok;
    for (int it = 0; it < 30; it++) begin
      rx_q.delete();
      order_q.delete();
      exp_b.delete();
      exp_ord.delete();
      base = done_cnt;
      r = $urandom_range(0, 9);
      op = (r < 3) ? 8'h01 : (r < 6) ? 8'h02 : (r < 8) ? 8'h03 : 8'($urandom);
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {4'h0, 4'($urandom)};
      c = {op, a, 8'($urandom)};
      t = 16'($urandom);
      kind = $urandom_range(0, 9);
      if (kind >= 8) begin
        exp_ord.push_back(mprio);
        exp_ord.push_back(~mprio);
        mprio = ~mprio;
      end else exp_ord.push_back(kind >= 6);
      foreach (exp_ord[i]) begin
        if (exp_ord[i]) begin
          exp_b.push_back(8'h7E); exp_b.push_back(t[15:8]); exp_b.push_back(t[7:0]);
        end else exp_b.push_back(model_reply(c));
      end
      cmd = c;
      tel_data = t;
      if (kind < 6 || kind >= 8) cmd_rdy = 1'b1;
      if (kind >= 6) tel_req = 1'b1;
      wait_done(base + exp_b.size(), 400, ok);
      n_checks++;
      if (!ok || rx_q.size() != exp_b.size() || order_q.size() != exp_ord.size()) begin
        n_fail++;
        $display("FAIL rand%0d_count: ok=%0b bytes=%0d grants=%0d, required bytes=%0d grants=%0d", it, ok,
                 rx_q.size(), order_q.size(), exp_b.size(), exp_ord.size());
      end
      for (int i = 0; i < exp_ord.size(); i++) begin
        n_checks++;
        if (i >= order_q.size() || order_q[i] !== exp_ord[i]) begin
          n_fail++;
          $display("FAIL rand%0d_order%0d: got %0d, required %0d", it, i,
                   (i < order_q.size()) ? order_q[i] : 1'b0, exp_ord[i]);
        end
      end
      for (int i = 0; i < exp_b.size(); i++) begin
        n_checks++;
        if (i >= rx_q.size() || rx_q[i] !== exp_b[i]) begin
          n_fail++;
          $display("FAIL rand%0d_byte%0d cmd=%h: got %h, required %h", it, i, c,
                   (i < rx_q.size()) ? rx_q[i] : 8'h00, exp_b[i]);
        end
      end
    end
    n_checks++;
    if (we_cnt != mwe) begin
      n_fail++;
      $display("FAIL we_total: got %0d write strobes, required %0d", we_cnt, mwe);
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (bank[i] !== mregs[i]) begin
        n_fail++;
        $display("FAIL bank%0d: got %h, required %h", i, bank[i], mregs[i]);
      end
    end
  endtask

  initial begin : main
    for (int i = 0; i < 16; i++) begin
      mregs[i] = 8'($urandom);
      bank[i] = mregs[i];
    end
    test_reset();
    test_write();
    test_read();
    test_nak();
    test_telemetry();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
